// File: rtl/camera_sequencer_if.sv
// Control/status bundle between the user logic and the pixel-array sequencer.
// master = controlling side, slave = sequencer.
interface camera_sequencer_if #(
    parameter int NUM_ROWS = 2,
    parameter int EXP_W    = 7
);
    logic                Init;
    logic                Continuous;
    logic                Exp_increase;
    logic                Exp_decrease;
    logic [NUM_ROWS-1:0] NRE;
    logic                ADC;
    logic                Erase;
    logic                Expose;
    logic                Busy;
    logic                Frame_done;
    logic [EXP_W-1:0]    Exp_time;

    modport master (
        output Init, Continuous, Exp_increase, Exp_decrease,
        input  NRE, ADC, Erase, Expose, Busy, Frame_done, Exp_time
    );

    modport slave (
        input  Init, Continuous, Exp_increase, Exp_decrease,
        output NRE, ADC, Erase, Expose, Busy, Frame_done, Exp_time
    );
endinterface

// File: rtl/camera_sequencer.sv
// Erase / exposure / per-row readout / ADC strobe sequencer for an N-row pixel array.
// Outputs are registered from the next-state decode, so they line up with the state cycle.
module camera_sequencer #(
    parameter int NUM_ROWS    = 2,
    parameter int EXP_W       = 7,
    parameter int EXP_DEFAULT = 10,
    parameter int EXP_MIN     = 2,
    parameter int EXP_MAX     = 70,
    parameter int READ_CYCLES = 8,
    parameter int ADC_POS     = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    camera_sequencer_if.slave  bus
);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int RC_W  = (READ_CYCLES > 1) ? $clog2(READ_CYCLES) : 1;
    localparam int CNT_W = (EXP_W > RC_W) ? EXP_W : RC_W;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_EXPOSURE = 2'd1;
    localparam logic [1:0] S_READOUT  = 2'd2;
    localparam logic [1:0] S_GAP      = 2'd3;

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [ROW_W-1:0] row, row_n;
    logic [EXP_W-1:0] exp_frame, exp_frame_n;
    logic [EXP_W-1:0] exp_time_n;
    logic [CNT_W-1:0] exp_last;
    logic             frame_done_n;

    // exp_frame never drops below EXP_MIN (>=1), so this cannot underflow
    assign exp_last = CNT_W'(exp_frame) - CNT_W'(1);

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        row_n        = row;
        exp_frame_n  = exp_frame;
        frame_done_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.Init || bus.Continuous) begin
                    state_n     = S_EXPOSURE;
                    cnt_n       = '0;
                    exp_frame_n = bus.Exp_time;
                end
            end
            S_EXPOSURE: begin
                if (cnt == exp_last) begin
                    state_n = S_READOUT;
                    cnt_n   = '0;
                    row_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_READOUT: begin
                if (cnt == CNT_W'(READ_CYCLES - 1)) begin
                    cnt_n = '0;
                    if (row == ROW_W'(NUM_ROWS - 1)) begin
                        state_n      = S_IDLE;
                        frame_done_n = 1'b1;
                    end else begin
                        state_n = S_GAP;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_GAP: begin
                state_n = S_READOUT;
                row_n   = row + 1'b1;
                cnt_n   = '0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Increase wins when both are requested, even if it is already saturated
    always_comb begin
        exp_time_n = bus.Exp_time;
        if (bus.Exp_increase) begin
            if (bus.Exp_time < EXP_W'(EXP_MAX))
                exp_time_n = bus.Exp_time + 1'b1;
        end else if (bus.Exp_decrease) begin
            if (bus.Exp_time > EXP_W'(EXP_MIN))
                exp_time_n = bus.Exp_time - 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            row            <= '0;
            exp_frame      <= EXP_W'(EXP_DEFAULT);
            bus.NRE        <= '1;
            bus.ADC        <= 1'b0;
            bus.Erase      <= 1'b1;
            bus.Expose     <= 1'b0;
            bus.Busy       <= 1'b0;
            bus.Frame_done <= 1'b0;
            bus.Exp_time   <= EXP_W'(EXP_DEFAULT);
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            row            <= row_n;
            exp_frame      <= exp_frame_n;
            bus.NRE        <= (state_n == S_READOUT) ? ~(NUM_ROWS'(1) << row_n) : '1;
            bus.ADC        <= (state_n == S_READOUT) && (cnt_n == CNT_W'(ADC_POS));
            bus.Erase      <= (state_n == S_IDLE);
            bus.Expose     <= (state_n == S_EXPOSURE);
            bus.Busy       <= (state_n != S_IDLE);
            bus.Frame_done <= frame_done_n;
            bus.Exp_time   <= exp_time_n;
        end
    end
endmodule

// File: tb/tb_camera_sequencer.sv
// Scoreboard bench: expected per-cycle output vectors are queued from the frame timeline
// and popped against the DUT one cycle at a time; a second instance covers 4 rows.
module tb_camera_sequencer;
    localparam int NR   = 2;
    localparam int RC   = 8;
    localparam int AP   = 4;
    localparam int EW   = 7;
    localparam int NR_B = 4;
    localparam int RC_B = 3;
    localparam int AP_B = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    camera_sequencer_if #(.NUM_ROWS(NR),   .EXP_W(EW)) bus_a ();
    camera_sequencer_if #(.NUM_ROWS(NR_B), .EXP_W(EW)) bus_b ();

    camera_sequencer #(
        .NUM_ROWS(NR), .EXP_W(EW), .EXP_DEFAULT(10), .EXP_MIN(2), .EXP_MAX(70),
        .READ_CYCLES(RC), .ADC_POS(AP)
    ) dut_a (
        .Clk(clk), .Reset(rst), .bus(bus_a)
    );

    camera_sequencer #(
        .NUM_ROWS(NR_B), .EXP_W(EW), .EXP_DEFAULT(2), .EXP_MIN(2), .EXP_MAX(70),
        .READ_CYCLES(RC_B), .ADC_POS(AP_B)
    ) dut_b (
        .Clk(clk), .Reset(rst), .bus(bus_b)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc;
    logic [6:0] exp_q_a[$];
    logic [8:0] exp_q_b[$];
    logic [6:0] want_a;
    logic [8:0] want_b;

    // Packed observation: {NRE, ADC, Erase, Expose, Busy, Frame_done}
    function automatic logic [6:0] obs_a();
        return {bus_a.NRE, bus_a.ADC, bus_a.Erase, bus_a.Expose, bus_a.Busy, bus_a.Frame_done};
    endfunction

    function automatic logic [8:0] obs_b();
        return {bus_b.NRE, bus_b.ADC, bus_b.Erase, bus_b.Expose, bus_b.Busy, bus_b.Frame_done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus_a.Init = 0; bus_a.Continuous = 0; bus_a.Exp_increase = 0; bus_a.Exp_decrease = 0;
        bus_b.Init = 0; bus_b.Continuous = 0; bus_b.Exp_increase = 0; bus_b.Exp_decrease = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    // One frame from the first exposure cycle through the Frame_done idle cycle
    task automatic push_frame_a(input int e);
        logic [1:0] n;
        for (int i = 0; i < e; i++) exp_q_a.push_back(7'b11_0_0_1_1_0);
        for (int r = 0; r < NR; r++) begin
            for (int c = 0; c < RC; c++) begin
                n = '1;
                n[r] = 1'b0;
                exp_q_a.push_back({n, (c == AP), 1'b0, 1'b0, 1'b1, 1'b0});
            end
            if (r < NR - 1) exp_q_a.push_back(7'b11_0_0_0_1_0);
        end
        exp_q_a.push_back(7'b11_0_1_0_0_1);
    endtask

    task automatic push_idle_a(input int k);
        for (int i = 0; i < k; i++) exp_q_a.push_back(7'b11_0_1_0_0_0);
    endtask

    task automatic push_frame_b(input int e);
        logic [3:0] n;
        for (int i = 0; i < e; i++) exp_q_b.push_back(9'b1111_0_0_1_1_0);
        for (int r = 0; r < NR_B; r++) begin
            for (int c = 0; c < RC_B; c++) begin
                n = '1;
                n[r] = 1'b0;
                exp_q_b.push_back({n, (c == AP_B), 1'b0, 1'b0, 1'b1, 1'b0});
            end
            if (r < NR_B - 1) exp_q_b.push_back(9'b1111_0_0_0_1_0);
        end
        exp_q_b.push_back(9'b1111_0_1_0_0_1);
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if (obs_a() !== 7'b11_0_1_0_0_0) begin
            n_bad++;
            $display("FAIL reset_outputs_a: got %b want %b", obs_a(), 7'b11_0_1_0_0_0);
        end
        n_vec++;
        if (bus_a.Exp_time !== 7'd10) begin
            n_bad++;
            $display("FAIL reset_exp_a: got %0d want 10", bus_a.Exp_time);
        end
        n_vec++;
        if (obs_b() !== 9'b1111_0_1_0_0_0) begin
            n_bad++;
            $display("FAIL reset_outputs_b: got %b want %b", obs_b(), 9'b1111_0_1_0_0_0);
        end
        n_vec++;
        if (bus_b.Exp_time !== 7'd2) begin
            n_bad++;
            $display("FAIL reset_exp_b: got %0d want 2", bus_b.Exp_time);
        end
    endtask

    task automatic test_single_frame();
        push_frame_a(10);
        push_idle_a(2);
        bus_a.Init = 1'b1;
        cyc = 0;
        while (exp_q_a.size() > 0) begin
            step();
            cyc++;
            bus_a.Init = 1'b0;
            want_a = exp_q_a.pop_front();
            n_vec++;
            if (obs_a() !== want_a) begin
                n_bad++;
                $display("FAIL single_frame cyc %0d: got %b want %b", cyc, obs_a(), want_a);
            end
        end
    endtask

    task automatic test_saturation();
        bus_a.Exp_increase = 1'b1;
        step();
        n_vec++;
        if (bus_a.Exp_time !== 7'd11) begin
            n_bad++;
            $display("FAIL sat_first_inc: got %0d want 11", bus_a.Exp_time);
        end
        repeat (64) step();
        bus_a.Exp_increase = 1'b0;
        n_vec++;
        if (bus_a.Exp_time !== 7'd70) begin
            n_bad++;
            $display("FAIL sat_max: got %0d want 70", bus_a.Exp_time);
        end
        bus_a.Exp_decrease = 1'b1;
        repeat (80) step();
        bus_a.Exp_decrease = 1'b0;
        n_vec++;
        if (bus_a.Exp_time !== 7'd2) begin
            n_bad++;
            $display("FAIL sat_min: got %0d want 2", bus_a.Exp_time);
        end
        bus_a.Exp_increase = 1'b1;
        repeat (8) step();
        bus_a.Exp_increase = 1'b0;
        n_vec++;
        if (bus_a.Exp_time !== 7'd10) begin
            n_bad++;
            $display("FAIL sat_back_to_10: got %0d want 10", bus_a.Exp_time);
        end
        bus_a.Exp_increase = 1'b1;
        bus_a.Exp_decrease = 1'b1;
        step();
        bus_a.Exp_increase = 1'b0;
        bus_a.Exp_decrease = 1'b0;
        n_vec++;
        if (bus_a.Exp_time !== 7'd11) begin
            n_bad++;
            $display("FAIL sat_both_priority: got %0d want 11", bus_a.Exp_time);
        end
        bus_a.Exp_decrease = 1'b1;
        step();
        bus_a.Exp_decrease = 1'b0;
        n_vec++;
        if (bus_a.Exp_time !== 7'd10) begin
            n_bad++;
            $display("FAIL sat_single_dec: got %0d want 10", bus_a.Exp_time);
        end
    endtask

    task automatic test_mid_frame_adjust();
        push_frame_a(10);
        bus_a.Init = 1'b1;
        cyc = 0;
        while (exp_q_a.size() > 0) begin
            step();
            cyc++;
            bus_a.Init = 1'b0;
            bus_a.Exp_increase = (cyc <= 5);
            want_a = exp_q_a.pop_front();
            n_vec++;
            if (obs_a() !== want_a) begin
                n_bad++;
                $display("FAIL mid_adjust_f1 cyc %0d: got %b want %b", cyc, obs_a(), want_a);
            end
        end
        bus_a.Exp_increase = 1'b0;
        n_vec++;
        if (bus_a.Exp_time !== 7'd15) begin
            n_bad++;
            $display("FAIL mid_adjust_exp: got %0d want 15", bus_a.Exp_time);
        end
        push_frame_a(15);
        bus_a.Init = 1'b1;
        cyc = 0;
        while (exp_q_a.size() > 0) begin
            step();
            cyc++;
            bus_a.Init = 1'b0;
            want_a = exp_q_a.pop_front();
            n_vec++;
            if (obs_a() !== want_a) begin
                n_bad++;
                $display("FAIL mid_adjust_f2 cyc %0d: got %b want %b", cyc, obs_a(), want_a);
            end
        end
    endtask

    task automatic test_continuous();
        do_reset();
        push_frame_a(10);
        push_frame_a(10);
        push_idle_a(3);
        bus_a.Continuous = 1'b1;
        cyc = 0;
        while (exp_q_a.size() > 0) begin
            step();
            cyc++;
            if (cyc == 40) bus_a.Continuous = 1'b0;
            want_a = exp_q_a.pop_front();
            n_vec++;
            if (obs_a() !== want_a) begin
                n_bad++;
                $display("FAIL continuous cyc %0d: got %b want %b", cyc, obs_a(), want_a);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_reset();
        bus_a.Exp_increase = 1'b1;
        step();
        step();
        bus_a.Exp_increase = 1'b0;
        push_frame_a(12);
        bus_a.Init = 1'b1;
        cyc = 0;
        while (cyc < 14) begin
            step();
            cyc++;
            bus_a.Init = 1'b0;
            want_a = exp_q_a.pop_front();
            n_vec++;
            if (obs_a() !== want_a) begin
                n_bad++;
                $display("FAIL reset_mid_pre cyc %0d: got %b want %b", cyc, obs_a(), want_a);
            end
        end
        exp_q_a.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_vec++;
        if (obs_a() !== 7'b11_0_1_0_0_0) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got %b want %b", obs_a(), 7'b11_0_1_0_0_0);
        end
        n_vec++;
        if (bus_a.Exp_time !== 7'd10) begin
            n_bad++;
            $display("FAIL reset_mid_exp: got %0d want 10", bus_a.Exp_time);
        end
        push_idle_a(4);
        while (exp_q_a.size() > 0) begin
            step();
            want_a = exp_q_a.pop_front();
            n_vec++;
            if (obs_a() !== want_a) begin
                n_bad++;
                $display("FAIL reset_mid_idle: got %b want %b", obs_a(), want_a);
            end
        end
    endtask

    task automatic test_four_rows();
        push_frame_b(2);
        bus_b.Init = 1'b1;
        cyc = 0;
        while (exp_q_b.size() > 0) begin
            step();
            cyc++;
            bus_b.Init = 1'b0;
            want_b = exp_q_b.pop_front();
            n_vec++;
            if (obs_b() !== want_b) begin
                n_bad++;
                $display("FAIL four_rows cyc %0d: got %b want %b", cyc, obs_b(), want_b);
            end
        end
        n_vec++;
        if (cyc != 18) begin
            n_bad++;
            $display("FAIL four_rows_len: got %0d want 18", cyc);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_saturation();
        test_mid_frame_adjust();
        test_continuous();
        test_reset_mid_frame();
        test_four_rows();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
